// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : data_mem_ctrl                                              |
// | Description : Load/store controller between a core request/response     |
// |               channel and a single-port, registered-address data RAM.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module data_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [4:0]  mem_r_addr,
  output logic [4:0]  mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic        mem_wren,
  input  logic [31:0] mem_r_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;

  state_t      r_state;
  logic [4:0]  r_word;
  logic [1:0]  r_offset;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic        r_illegal;

  logic        w_illegal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  always_comb begin
    w_illegal = 1'b0;
    case (req_size)
      c_SIZE_BYTE: w_illegal = 1'b0;
      c_SIZE_HALF: w_illegal = req_addr[0];
      c_SIZE_WORD: w_illegal = (req_addr[1:0] != 2'b00);
      default:     w_illegal = 1'b1;
    endcase
  end

  // Little-endian lane select and extension of the old word for loads.
  always_comb begin
    w_byte = mem_r_data[7:0];
    case (r_offset)
      2'd0:    w_byte = mem_r_data[7:0];
      2'd1:    w_byte = mem_r_data[15:8];
      2'd2:    w_byte = mem_r_data[23:16];
      default: w_byte = mem_r_data[31:24];
    endcase
    w_half = r_offset[1] ? mem_r_data[31:16] : mem_r_data[15:0];
    case (r_size)
      c_SIZE_BYTE: w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      c_SIZE_HALF: w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
      default:     w_load_data = mem_r_data;
    endcase
  end

  // Read-modify-write: only the addressed lanes are replaced.
  always_comb begin
    w_merged = mem_r_data;
    case (r_size)
      c_SIZE_BYTE: begin
        case (r_offset)
          2'd0:    w_merged[7:0]   = r_wdata[7:0];
          2'd1:    w_merged[15:8]  = r_wdata[7:0];
          2'd2:    w_merged[23:16] = r_wdata[7:0];
          default: w_merged[31:24] = r_wdata[7:0];
        endcase
      end
      c_SIZE_HALF: begin
        if (r_offset[1]) w_merged[31:16] = r_wdata[15:0];
        else             w_merged[15:0]  = r_wdata[15:0];
      end
      default: w_merged = r_wdata;
    endcase
  end

  assign mem_r_addr = r_word;
  assign mem_w_addr = r_word;
  assign mem_w_data = mem_wren ? 32'h0000_0000 : w_merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_word     <= 5'd0;
      r_offset   <= 2'd0;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'h0000_0000;
      r_illegal  <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      mem_wren   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_word     <= req_addr[6:2];
            r_offset   <= req_addr[1:0];
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_illegal  <= w_illegal;
            req_ready  <= 1'b0;
            r_state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // Rejected requests skip the memory access entirely.
          if (r_illegal) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0000_0000;
            r_state    <= ST_RESP;
          end else begin
            mem_wren <= ~r_we;
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_wren   <= 1'b1;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= r_we ? 32'h0000_0000 : w_load_data;
          r_state    <= ST_RESP;
        end
        default: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// Scoreboard bench for data_mem_ctrl with a behavioural registered-address RAM.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [6:0]  req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  mem_r_addr, mem_w_addr;
  logic [31:0] mem_w_data, mem_r_data;
  logic        mem_wren;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .mem_wren(mem_wren), .mem_r_data(mem_r_data)
  );

  // Data RAM: address registered each edge, active-low write to the previously registered word.
  logic [31:0] mem [0:31];
  logic [4:0]  mem_q = 5'd0;
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [31:0] pl_val = 32'h0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (pl_en)          mem[pl_idx] <= pl_val;
    else if (!mem_wren) mem[mem_q]  <= mem_w_data;
    if (!mem_wren) wr_cnt <= wr_cnt + 1;
    mem_q <= mem_r_addr;
  end
  assign mem_r_data = mem[mem_q];

  logic [7:0] gold [0:127];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [6:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = size_bytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = gold[int'(a) + i];
    if (!uns && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic void model_store(input logic [6:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < size_bytes(sz); i++) gold[int'(a) + i] = wd[8*i +: 8];
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 5'(idx); pl_val = val;
    for (int i = 0; i < 4; i++) gold[4*idx + i] = val[8*i +: 8];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive_junk();
    req_valid = 1'b1;
    req_addr  = 7'($urandom);
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr[1:0] = 2'b00;
    req_unsigned = 1'b0;
    req_wdata = $urandom;
  endtask

  // One transaction: push expectation, drive, wait for response, compare, optionally stall, handshake.
  task automatic run_req(input logic [6:0] a, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, input int hold);
    exp_t e, got;
    logic ill;
    int   n, w0;
    ill = (sz == 2'b11) || ((int'(a) % size_bytes(sz)) != 0);
    e.err    = ill;
    e.lat    = ill ? 1 : 2;
    e.writes = (we && !ill) ? 1 : 0;
    e.rdata  = (ill || we) ? 32'h0 : model_load(a, sz, uns);
    if (we && !ill) model_store(a, sz, wd);
    sb.push_back(e);

    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz;
    req_unsigned = uns; req_wdata = wd;
    w0 = wr_cnt;
    @(negedge clk);
    drive_junk();
    n = 0;
    while (resp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_timeout addr=%h: no resp_valid within %0d cycles", a, n);
    end else begin
      if (n !== got.lat) begin
        miscompares++;
        $display("FAIL latency addr=%h: got %0d expected %0d", a, n, got.lat);
      end
      vectors++;
      if (resp_rdata !== got.rdata || resp_err !== got.err) begin
        miscompares++;
        $display("FAIL resp addr=%h: got rdata=%h err=%b expected rdata=%h err=%b",
                 a, resp_rdata, resp_err, got.rdata, got.err);
      end
      vectors++;
      if (mem_r_addr !== a[6:2] || mem_w_addr !== a[6:2]) begin
        miscompares++;
        $display("FAIL mem_addr addr=%h: got r=%h w=%h expected %h", a, mem_r_addr, mem_w_addr, a[6:2]);
      end
    end
    for (int c = 0; c < hold; c++) begin
      drive_junk();
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== got.rdata ||
          resp_err !== got.err || mem_r_addr !== a[6:2]) begin
        miscompares++;
        $display("FAIL stall%0d: got valid=%b ready=%b rdata=%h err=%b waddr=%h expected 1 0 %h %b %h",
                 c, resp_valid, req_ready, resp_rdata, resp_err, mem_r_addr, got.rdata, got.err, a[6:2]);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL handshake: got valid=%b ready=%b expected 0 1", resp_valid, req_ready);
    end
    vectors++;
    if ((wr_cnt - w0) !== got.writes) begin
      miscompares++;
      $display("FAIL write_count addr=%h: got %0d expected %0d", a, wr_cnt - w0, got.writes);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
        mem_wren !== 1'b1 || mem_r_addr !== 5'd0 || mem_w_addr !== 5'd0 || mem_w_data !== 32'h0) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b vld=%b rdata=%h err=%b wren=%b ra=%h wa=%h wd=%h expected 1 0 0 0 1 0 0 0",
               tag, req_ready, resp_valid, resp_rdata, resp_err, mem_wren, mem_r_addr, mem_w_addr, mem_w_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 7'd0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
    for (int i = 0; i < 32; i++) preload(i, $urandom);
    check_reset_outputs("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");
  endtask

  task automatic test_load_byte();
    preload(3, 32'h1122_3344);
    run_req(7'h0F, 1'b0, 2'b00, 1'b0, 32'h0, 0);
  endtask

  task automatic test_store_half();
    run_req(7'h0E, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF, 0);
    run_req(7'h0C, 1'b0, 2'b10, 1'b0, 32'h0, 0);
    vectors++;
    if (mem[3] !== 32'hBEEF_3344) begin
      miscompares++;
      $display("FAIL store_half_word3: got %h expected beef3344", mem[3]);
    end
  endtask

  task automatic test_sign_ext();
    preload(0, 32'h0000_00F0);
    run_req(7'h00, 1'b0, 2'b00, 1'b0, 32'h0, 0);
    run_req(7'h00, 1'b0, 2'b00, 1'b1, 32'h0, 0);
    run_req(7'h0E, 1'b0, 2'b01, 1'b0, 32'h0, 0);
    run_req(7'h0E, 1'b0, 2'b01, 1'b1, 32'h0, 0);
  endtask

  task automatic test_misaligned();
    run_req(7'h05, 1'b0, 2'b10, 1'b0, 32'h0, 0);
    run_req(7'h0D, 1'b1, 2'b01, 1'b0, 32'h1234_5678, 0);
    run_req(7'h0E, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 0);
    run_req(7'h10, 1'b1, 2'b11, 1'b0, 32'hDEAD_BEEF, 0);
    run_req(7'h0C, 1'b0, 2'b10, 1'b0, 32'h0, 0);
  endtask

  task automatic test_backpressure();
    run_req(7'h0F, 1'b0, 2'b00, 1'b1, 32'h0, 5);
    run_req(7'h07, 1'b0, 2'b11, 1'b0, 32'h0, 5);
  endtask

  task automatic test_reset_in_access();
    preload(5, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 7'h14; req_we = 1'b1; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_wren !== 1'b0) begin
      miscompares++;
      $display("FAIL access_wren: got %b expected 0", mem_wren);
    end
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (mem[5] !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL reset_no_write: got %h expected cafef00d", mem[5]);
    end
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("after_abort");
  endtask

  task automatic test_random();
    logic [6:0]  a;
    logic [1:0]  sz;
    for (int t = 0; t < 40; t++) begin
      a  = 7'($urandom);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b11) sz = 2'b10;
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      run_req(a, 1'($urandom), sz, 1'($urandom), $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_sign_ext();
    test_misaligned();
    test_backpressure();
    test_reset_in_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
